delay_tap_ctrl: RTL and testbench

- Initiator for the output/input delay-tap adjust interface: drives DLY_LOAD / DLY_ADJ / DLY_INCDEC and reads back DLY_TAP_VALUE.
- Walks the delay primitive's 6-bit tap to a requested TARGET_TAP, one ADJ pulse per step.
- Sits in fabric next to each O_DELAY / I_DELAY instance, used by training/calibration logic.
- Reports BUSY, a one-cycle DONE and a sticky ERROR.

---
 rtl/delay_tap_pkg.sv | 16 +
 rtl/delay_tap_settle_cnt.sv | 21 ++
 rtl/delay_tap_ctrl.sv | 108 ++++++++++
 tb/tb_delay_tap_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/delay_tap_pkg.sv
// delay_tap_pkg: shared types and widths for the delay-tap adjust controller.
package delay_tap_pkg;
    localparam int TAP_WIDTH      = 6;
    localparam logic [TAP_WIDTH-1:0] TAP_MAX = 6'd63;
    localparam int STEP_CNT_WIDTH = 7;
    localparam int SETTLE_WIDTH   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_COMPARE,
        S_STEP,
        S_FINISH
    } state_e;
endpackage

// File: rtl/delay_tap_settle_cnt.sv
// delay_tap_settle_cnt: loadable down-counter with zero flag; holds at zero.
module delay_tap_settle_cnt
    import delay_tap_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [SETTLE_WIDTH-1:0] load_val,
    output logic                    zero
);
    logic [SETTLE_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        zero  = cnt_q == '0;
        cnt_d = load ? load_val : zero ? cnt_q : cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/delay_tap_ctrl.sv
// delay_tap_ctrl: walks a delay primitive's tap to a requested target with LOAD/ADJ pulses.
// Define DELAY_TAP_CTRL_STUCK_CHECK_EN to flag a step that leaves the tap unchanged.
module delay_tap_ctrl
    import delay_tap_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_STEPS     = 64
) (
    input  logic                 CLK_IN,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 RELOAD,
    input  logic [TAP_WIDTH-1:0] TARGET_TAP,
    input  logic [TAP_WIDTH-1:0] DLY_TAP_VALUE,
    output logic                 DLY_LOAD,
    output logic                 DLY_ADJ,
    output logic                 DLY_INCDEC,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERROR
);
    state_e                    state_q, state_d;
    logic [TAP_WIDTH-1:0]      target_q, target_d;
    logic [STEP_CNT_WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic                      incdec_q, incdec_d;
    logic                      error_q, error_d;
    logic                      accept, tap_hit, stuck, err_now;
    logic                      settle_load, settle_zero;

`ifdef DELAY_TAP_CTRL_STUCK_CHECK_EN
    logic [TAP_WIDTH-1:0] pre_tap_q, pre_tap_d;

    // Every COMPARE with a nonzero step count follows a STEP, so pre_tap_q is fresh.
    always_comb begin
        pre_tap_d = state_q == S_STEP ? DLY_TAP_VALUE : pre_tap_q;
        stuck     = step_cnt_q != '0 && DLY_TAP_VALUE == pre_tap_q;
    end

    always_ff @(posedge CLK_IN or posedge RST)
        if (RST) pre_tap_q <= '0;
        else     pre_tap_q <= pre_tap_d;
`else
    always_comb stuck = 1'b0;
`endif

    always_comb begin
        accept  = state_q == S_IDLE && START;
        tap_hit = DLY_TAP_VALUE == target_q;
        err_now = state_q == S_COMPARE && !tap_hit &&
                  (step_cnt_q == STEP_CNT_WIDTH'(MAX_STEPS) || stuck);
    end

    always_ff @(posedge CLK_IN or posedge RST)
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    state_d = !START ? S_IDLE : RELOAD ? S_LOAD : S_COMPARE;
            S_LOAD:    state_d = S_SETTLE;
            S_STEP:    state_d = S_SETTLE;
            S_SETTLE:  state_d = settle_zero ? S_COMPARE : S_SETTLE;
            S_COMPARE: state_d = tap_hit ? S_FINISH : err_now ? S_IDLE : S_STEP;
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        DLY_LOAD   = state_q == S_LOAD;
        DLY_ADJ    = state_q == S_STEP;
        DLY_INCDEC = incdec_q;
        DONE       = state_q == S_FINISH;
        BUSY       = state_q != S_IDLE && state_q != S_FINISH && !err_now;
        ERROR      = error_q || err_now;
    end

    // Direction is latched in COMPARE so it stays put through STEP and SETTLE.
    always_comb begin
        target_d    = accept ? TARGET_TAP : target_q;
        step_cnt_d  = accept ? '0 : state_q == S_STEP ? step_cnt_q + 1'b1 : step_cnt_q;
        incdec_d    = state_q == S_COMPARE ? target_q > DLY_TAP_VALUE : incdec_q;
        error_d     = accept ? 1'b0 : err_now ? 1'b1 : error_q;
        settle_load = state_q == S_LOAD || state_q == S_STEP;
    end

    always_ff @(posedge CLK_IN or posedge RST)
        if (RST) begin
            target_q   <= '0;
            step_cnt_q <= '0;
            incdec_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            target_q   <= target_d;
            step_cnt_q <= step_cnt_d;
            incdec_q   <= incdec_d;
            error_q    <= error_d;
        end

    delay_tap_settle_cnt u_settle (
        .clk      (CLK_IN),
        .rst      (RST),
        .load     (settle_load),
        .load_val (SETTLE_WIDTH'(SETTLE_CYCLES - 1)),
        .zero     (settle_zero)
    );
endmodule

// File: tb/tb_delay_tap_ctrl.sv
// tb_delay_tap_ctrl: scoreboard bench for delay_tap_ctrl with a saturating tap model.
module tb_delay_tap_ctrl;
    localparam int SETTLE = 2;
    localparam int MAXS   = 64;
    localparam int GAP    = SETTLE + 2;

    logic       CLK_IN = 0, RST = 1, START = 0, RELOAD = 0;
    logic [5:0] TARGET_TAP = 0, DLY_TAP_VALUE = 0;
    logic       DLY_LOAD, DLY_ADJ, DLY_INCDEC, BUSY, DONE, ERROR;
    logic [5:0] delay_val = 0;
    logic       frozen = 0;
    int         cyc = 0, total = 0, bad = 0;

    typedef struct {
        int err;
        int tap;
        int adj;
        int inc;
        int load;
        int start_cyc;
        int lat;
    } exp_t;
    exp_t exp_q[$];

    delay_tap_ctrl #(.SETTLE_CYCLES(SETTLE), .MAX_STEPS(MAXS)) dut (
        .CLK_IN        (CLK_IN),
        .RST           (RST),
        .START         (START),
        .RELOAD        (RELOAD),
        .TARGET_TAP    (TARGET_TAP),
        .DLY_TAP_VALUE (DLY_TAP_VALUE),
        .DLY_LOAD      (DLY_LOAD),
        .DLY_ADJ       (DLY_ADJ),
        .DLY_INCDEC    (DLY_INCDEC),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ERROR         (ERROR)
    );

    always #5 CLK_IN = ~CLK_IN;
    always @(posedge CLK_IN) cyc <= cyc + 1;

    // Primitive model: load or saturating step on the clock edge where the pulse is high.
    always @(posedge CLK_IN)
        if (DLY_LOAD) DLY_TAP_VALUE <= delay_val;
        else if (DLY_ADJ && !frozen)
            DLY_TAP_VALUE <= DLY_INCDEC ? (DLY_TAP_VALUE == 6'd63 ? 6'd63 : DLY_TAP_VALUE + 6'd1)
                                        : (DLY_TAP_VALUE == 6'd0  ? 6'd0  : DLY_TAP_VALUE - 6'd1);

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic issue(input int tgt, input int rel, input int err, input int tap,
                         input int adj, input int inc, input int load, input int lat);
        exp_t e;
        @(posedge CLK_IN); #1;
        START = 1; RELOAD = rel[0]; TARGET_TAP = tgt[5:0];
        e = '{err, tap, adj, inc, load, cyc, lat};
        exp_q.push_back(e);
        @(posedge CLK_IN); #1;
        START = 0; RELOAD = 0;
        check("busy_after_start", BUSY, 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge CLK_IN);
            n++;
        end
        check("completion_timeout", exp_q.size(), 0);
        exp_q.delete();
        #1 check("busy_low_after", BUSY, 0);
    endtask

    // Monitor: counts pulses, checks spacing/limits, scores each DONE or ERROR event.
    initial begin
        exp_t e;
        int adj_n = 0, inc_n = 0, load_n = 0, last_adj = -1;
        logic err_prev = 0;
        forever begin
            @(negedge CLK_IN);
            if (RST) begin
                adj_n = 0; inc_n = 0; load_n = 0; last_adj = -1; err_prev = 0;
            end else begin
                if (DLY_LOAD) load_n++;
                if (DLY_ADJ) begin
                    if (last_adj >= 0) check("adj_gap", cyc - last_adj, GAP);
                    check("no_overrun", int'(DLY_INCDEC ? DLY_TAP_VALUE == 6'd63 : DLY_TAP_VALUE == 6'd0), 0);
                    adj_n++;
                    if (DLY_INCDEC) inc_n++;
                    last_adj = cyc;
                end
                if (DONE || (ERROR && !err_prev)) begin
                    if (exp_q.size() == 0) check("unexpected_completion", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("error_flag", ERROR, e.err);
                        check("done_flag", DONE, 1 - e.err);
                        check("final_tap", DLY_TAP_VALUE, e.tap);
                        check("adj_pulses", adj_n, e.adj);
                        check("inc_pulses", inc_n, e.inc);
                        check("load_pulses", load_n, e.load);
                        check("busy_at_end", BUSY, 0);
                        check("latency", cyc - e.start_cyc, e.lat);
                    end
                    adj_n = 0; inc_n = 0; load_n = 0; last_adj = -1;
                end
                err_prev = ERROR;
            end
        end
    end

    initial begin
        #12;
        check("rst_load", DLY_LOAD, 0);
        check("rst_adj", DLY_ADJ, 0);
        check("rst_incdec", DLY_INCDEC, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_error", ERROR, 0);
        @(posedge CLK_IN); #1 RST = 0;

        delay_val = 6'd4;
        issue(7, 1, 0, 7, 3, 3, 1, 5 + 3 * GAP);
        wait_done(400);
        issue(3, 0, 0, 3, 4, 0, 0, 2 + 4 * GAP);
        wait_done(400);
        issue(3, 0, 0, 3, 0, 0, 0, 2);
        wait_done(400);

        delay_val = 6'd0;
        issue(63, 1, 0, 63, 63, 63, 1, 5 + 63 * GAP);
        wait_done(400);
        issue(0, 0, 0, 0, 63, 0, 0, 2 + 63 * GAP);
        wait_done(400);

        frozen = 1; delay_val = 6'd10;
`ifdef DELAY_TAP_CTRL_STUCK_CHECK_EN
        issue(12, 1, 1, 10, 1, 1, 1, 4 + GAP);
`else
        issue(12, 1, 1, 10, MAXS, MAXS, 1, 4 + MAXS * GAP);
`endif
        wait_done(400);
        check("error_sticky", ERROR, 1);
        frozen = 0;

        issue(20, 0, 0, 20, 10, 10, 0, 2 + 10 * GAP);
        @(posedge CLK_IN);
        @(posedge CLK_IN); #3;
        check("incdec_held_in_settle", DLY_INCDEC, 1);
        RST = 1;
        exp_q.delete();
        #1;
        check("async_rst_adj", DLY_ADJ, 0);
        check("async_rst_load", DLY_LOAD, 0);
        check("async_rst_incdec", DLY_INCDEC, 0);
        check("async_rst_busy", BUSY, 0);
        check("async_rst_done", DONE, 0);
        check("async_rst_error", ERROR, 0);
        @(posedge CLK_IN); #2 RST = 0;
        #1 check("idle_after_rst", BUSY, 0);

        issue(14, 0, 0, 14, 3, 3, 0, 2 + 3 * GAP);
        @(posedge CLK_IN); #1;
        START = 1; RELOAD = 1; TARGET_TAP = 6'd40;
        @(posedge CLK_IN); #1;
        TARGET_TAP = 6'd0;
        @(posedge CLK_IN); #1;
        START = 0; RELOAD = 0;
        wait_done(400);
        check("tap_after_ignored_start", DLY_TAP_VALUE, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
